// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline types and constants: field widths, control-bit indices,
// occupancy encodings and the buffered entry struct.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 8;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;

    // Buffer occupancy encodings
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wd;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
    } exmem_entry_t;

    // Head entry writes a non-zero register with an ALU result (loads resolve later)
    function automatic logic fwd_ok(input exmem_entry_t e);
        return e.ctrl[CTRL_REGWRITE] && (e.rd != '0) && !e.ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Enable + synchronous-clear register holding one EX->MEM entry.
module pipe_entry_reg
    import pipe_pkg::*;
(
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  exmem_entry_t d_i,
    output exmem_entry_t q_o
);

    exmem_entry_t q_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ex_mem_buffer.sv
// EX->MEM pipeline buffer: 2-entry (head + skid) valid/ready buffer with sync flush.
// Define BF2_FWD_EN to add the head-entry forwarding outputs toward the EX bypass mux.
module ex_mem_buffer
    import pipe_pkg::*;
(
    input  logic              clk_BF2,
    input  logic              rst_BF2,
    input  logic              flush_BF2,
    input  logic              in_valid_BF2,
    output logic              in_ready_BF2,
    input  logic [DATA_W-1:0] aluIn_BF2,
    input  logic [DATA_W-1:0] wdIn_BF2,
    input  logic [REG_W-1:0]  rdIn_BF2,
    input  logic [CTRL_W-1:0] ctrlIn_BF2,
    output logic              out_valid_BF2,
    input  logic              out_ready_BF2,
    output logic [DATA_W-1:0] aluBF2,
    output logic [DATA_W-1:0] wdBF2,
    output logic [REG_W-1:0]  rdBF2,
    output logic [CTRL_W-1:0] ctrlBF2
`ifdef BF2_FWD_EN
    ,
    output logic              fwdValid_BF2,
    output logic [REG_W-1:0]  fwdRd_BF2,
    output logic [DATA_W-1:0] fwdData_BF2
`endif
);

    logic [1:0]   state_q, state_d;
    logic         in_ready_q;
    logic         accept, xfer;
    logic         head_en, skid_en;
    exmem_entry_t in_entry, head_d, head_q, skid_q;

    assign in_entry = '{alu: aluIn_BF2, wd: wdIn_BF2, rd: rdIn_BF2, ctrl: ctrlIn_BF2};

    assign accept        = in_valid_BF2 & in_ready_q;
    assign out_valid_BF2 = (state_q != StEmpty);
    assign xfer          = out_valid_BF2 & out_ready_BF2;

    always_comb begin
        state_d = state_q;
        head_en = 1'b0;
        skid_en = 1'b0;
        head_d  = in_entry;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    head_en = 1'b1;
                end
            end
            StOne: begin
                if (accept && xfer) begin
                    head_en = 1'b1;
                end else if (accept) begin
                    state_d = StFull;
                    skid_en = 1'b1;
                end else if (xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only the skid-to-head move can happen
                if (xfer) begin
                    state_d = StOne;
                    head_en = 1'b1;
                    head_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops any same-cycle accept; head data is simply left stale
        if (flush_BF2) begin
            state_d = StEmpty;
            head_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk_BF2) begin
        if (rst_BF2) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
        end
    end

    pipe_entry_reg u_head (
        .clk_i (clk_BF2),
        .clr_i (rst_BF2),
        .en_i  (head_en),
        .d_i   (head_d),
        .q_o   (head_q)
    );

    pipe_entry_reg u_skid (
        .clk_i (clk_BF2),
        .clr_i (rst_BF2),
        .en_i  (skid_en),
        .d_i   (in_entry),
        .q_o   (skid_q)
    );

    assign in_ready_BF2 = in_ready_q;
    assign aluBF2       = head_q.alu;
    assign wdBF2        = head_q.wd;
    assign rdBF2        = head_q.rd;
    assign ctrlBF2      = head_q.ctrl;

`ifdef BF2_FWD_EN
    assign fwdValid_BF2 = out_valid_BF2 & fwd_ok(head_q);
    assign fwdRd_BF2    = head_q.rd;
    assign fwdData_BF2  = head_q.alu;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Self-checking bench for ex_mem_buffer: directed vector tables, hand sequences for
// flush/reset corner cases, and random traffic against a queue-based reference model.
module tb_ex_mem_buffer;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] alu_in, wd_in, alu, wd;
    logic [REG_W-1:0]  rd_in, rd;
    logic [CTRL_W-1:0] ctrl_in, ctrl;
`ifdef BF2_FWD_EN
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    ex_mem_buffer dut (
        .clk_BF2       (clk),
        .rst_BF2       (rst),
        .flush_BF2     (flush),
        .in_valid_BF2  (in_valid),
        .in_ready_BF2  (in_ready),
        .aluIn_BF2     (alu_in),
        .wdIn_BF2      (wd_in),
        .rdIn_BF2      (rd_in),
        .ctrlIn_BF2    (ctrl_in),
        .out_valid_BF2 (out_valid),
        .out_ready_BF2 (out_ready),
        .aluBF2        (alu),
        .wdBF2         (wd),
        .rdBF2         (rd),
        .ctrlBF2       (ctrl)
`ifdef BF2_FWD_EN
        ,
        .fwdValid_BF2  (fwd_valid),
        .fwdRd_BF2     (fwd_rd),
        .fwdData_BF2   (fwd_data)
`endif
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Reference model: FIFO contents, last presented head, and the ready flag
    exmem_entry_t mq[$];
    exmem_entry_t m_head = '0;
    logic         m_ready = 1'b1;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] a;
        logic        ev;
        logic        erdy;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exmem_entry_t mk(input logic [31:0] a);
        exmem_entry_t e;
        e.alu  = a;
        e.wd   = ~a;
        e.rd   = a[4:0];
        e.ctrl = a[7:0];
        return e;
    endfunction

    function automatic vec_t mkv(input logic iv, input logic ordy, input logic [31:0] a,
                                 input logic ev, input logic erdy, input logic [31:0] ea);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.a = a; v.ev = ev; v.erdy = erdy; v.ea = ea;
        return v;
    endfunction

    // Drive one cycle of inputs, cross the clock edge, then advance the model
    task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic rs,
                         input exmem_entry_t e);
        logic acc, xf;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        alu_in    = e.alu;
        wd_in     = e.wd;
        rd_in     = e.rd;
        ctrl_in   = e.ctrl;
        acc = iv & m_ready;
        xf  = (mq.size() != 0) & ordy;
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            m_head = '0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (xf) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        if (mq.size() != 0) m_head = mq[0];
        m_ready = (mq.size() < 2);
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready));
        check({tag, ".alu"}, 64'(alu), 64'(m_head.alu));
        check({tag, ".wd"}, 64'(wd), 64'(m_head.wd));
        check({tag, ".rd"}, 64'(rd), 64'(m_head.rd));
        check({tag, ".ctrl"}, 64'(ctrl), 64'(m_head.ctrl));
`ifdef BF2_FWD_EN
        check({tag, ".fwd_valid"}, 64'(fwd_valid),
              64'((mq.size() != 0) && m_head.ctrl[0] && (m_head.rd != 0) && !m_head.ctrl[1]));
        check({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(m_head.rd));
        check({tag, ".fwd_data"}, 64'(fwd_data), 64'(m_head.alu));
`endif
    endtask

    initial begin
        exmem_entry_t e;
        // Streaming at full rate: 1..8 with one-cycle latency, then drain
        for (int i = 1; i <= 8; i++) tbl.push_back(mkv(1'b1, 1'b1, 32'(i), 1'b1, 1'b1, 32'(i)));
        tbl.push_back(mkv(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h8));
        // Back-pressure into the skid, then release
        tbl.push_back(mkv(1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 32'hA));
        tbl.push_back(mkv(1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 32'hA));
        tbl.push_back(mkv(1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 32'hA));
        tbl.push_back(mkv(1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'hB));
        tbl.push_back(mkv(1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'hC));
        tbl.push_back(mkv(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hC));

        // Reset held for two cycles
        cycle(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h5));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, mk(32'h5));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(32'h0));
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.alu", 64'(alu), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);

        foreach (tbl[i]) begin
            cycle(tbl[i].iv, tbl[i].ordy, 1'b0, 1'b0, mk(tbl[i].a));
            check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].erdy));
            check($sformatf("vec%0d.alu", i), 64'(alu), 64'(tbl[i].ea));
            cmp_model($sformatf("vec%0d", i));
        end

        // Flush while FULL with a concurrent valid input
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h11));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h22));
        check("flush.pre_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, mk(32'h33));
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, mk(32'h0));
            check("flush.idle_valid", 64'(out_valid), 64'd0);
            check("flush.no_0x33", 64'(alu == 32'h33), 64'd0);
            cmp_model("flush");
        end

`ifdef BF2_FWD_EN
        e = '{alu: 32'hCAFE, wd: 32'h1, rd: 5'd5, ctrl: 8'h01};
        cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
        check("fwd.valid_rd5", 64'(fwd_valid), 64'd1);
        check("fwd.rd", 64'(fwd_rd), 64'd5);
        check("fwd.data", 64'(fwd_data), 64'hCAFE);
        e = '{alu: 32'hBEEF, wd: 32'h1, rd: 5'd0, ctrl: 8'h01};
        cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
        check("fwd.valid_rd0", 64'(fwd_valid), 64'd0);
        e = '{alu: 32'hF00D, wd: 32'h1, rd: 5'd5, ctrl: 8'h03};
        cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
        check("fwd.valid_load", 64'(fwd_valid), 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, mk(32'h0));
        check("fwd.valid_empty", 64'(fwd_valid), 64'd0);
`endif

        // Reset while FULL mid-stream
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h5A));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'hA5));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, mk(32'h44));
        check("rst_full.out_valid", 64'(out_valid), 64'd0);
        check("rst_full.in_ready", 64'(in_ready), 64'd1);
        check("rst_full.alu", 64'(alu), 64'd0);
        check("rst_full.wd", 64'(wd), 64'd0);
        check("rst_full.rd", 64'(rd), 64'd0);
        check("rst_full.ctrl", 64'(ctrl), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, mk(32'h0));
            check("rst_full.no_stale", 64'(out_valid), 64'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            e.alu  = $urandom;
            e.wd   = $urandom;
            e.rd   = REG_W'($urandom_range(0, 31));
            e.ctrl = CTRL_W'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0), e);
            cmp_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
